// File: rtl/seq_tx_pkg.sv
// Shared types for the serial pattern transmitter: FSM state encoding.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable left-shift register with a serial even-parity accumulator over the bits shifted out.
module seq_tx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o,
  output logic             next_msb_o,
  output logic             parity_o
);

  logic [WIDTH-1:0] sr_q;
  logic             par_q;

  // NOTE: non-blocking assignments make every flop sample pre-edge values, so shift and parity agree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else if (load_i) begin
      sr_q  <= data_i;
      par_q <= 1'b0;
    end else if (shift_i) begin
      sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
      par_q <= par_q ^ sr_q[WIDTH-1];
    end
  end

  assign msb_o      = sr_q[WIDTH-1];
  assign next_msb_o = sr_q[WIDTH-2];
  assign parity_o   = par_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: WIDTH data bits MSB first, optional even parity, then a done pulse.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          w_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  logic sr_msb;
  logic sr_next_msb;
  logic sr_parity;
  logic sr_load;
  logic sr_shift;

  assign sr_load  = (state_q == IDLE) && start;
  assign sr_shift = (state_q == SHIFT);

  seq_tx_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (sr_load),
    .shift_i   (sr_shift),
    .data_i    (data),
    .msb_o     (sr_msb),
    .next_msb_o(sr_next_msb),
    .parity_o  (sr_parity)
  );

  // Outputs are registered with the value for the upcoming cycle, so each transition preloads them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            cnt_q   <= LAST_CNT;
            w_q     <= data[WIDTH-1];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            w_q   <= sr_next_msb;
          end else if (PARITY_EN) begin
            state_q <= PARITY;
            w_q     <= sr_parity ^ sr_msb;
          end else begin
            state_q <= DONE;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        PARITY: begin
          state_q <= DONE;
          w_q     <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          w_q     <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign w     = w_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: one instance with parity, one without, sharing clock, reset and stimulus.
module tb_seq_pattern_tx;

  localparam int W = 8;

  localparam logic [3:0] B1 = 4'b1110;
  localparam logic [3:0] B0 = 4'b0110;
  localparam logic [3:0] DN = 4'b0011;
  localparam logic [3:0] ID = 4'b0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] data;

  logic w1, valid1, busy1, done1;
  logic w0, valid0, busy0, done0;
  logic [3:0] o1, o0;

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(W), .PARITY_EN(1'b1)) dut_p1 (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .w(w1), .valid(valid1), .busy(busy1), .done(done1)
  );

  seq_pattern_tx #(.WIDTH(W), .PARITY_EN(1'b0)) dut_p0 (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .w(w0), .valid(valid0), .busy(busy0), .done(done0)
  );

  assign o1 = {w1, valid1, busy1, done1};
  assign o0 = {w0, valid0, busy0, done0};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got {w,valid,busy,done}=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pos is the cycle index inside the current frame (0 = idle),
  // and the expected outputs are derived from that index and the captured payload.
  int           pos  [2];
  logic [W-1:0] fdat [2];

  function automatic int frame_len(input int m);
    return (m == 1) ? W + 2 : W + 1;
  endfunction

  function automatic logic [3:0] model_out(input int p, input logic [W-1:0] d, input bit pen);
    logic [3:0] r;
    if (p == 0)                r = ID;
    else if (p <= W)           r = {d[3'(W - p)], 3'b110};
    else if (pen && p == W + 1) r = {^d, 3'b110};
    else                       r = DN;
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        pos[m] = 0;
      end else if (pos[m] == 0) begin
        if (start) begin
          pos[m]  = 1;
          fdat[m] = data;
        end
      end else if (pos[m] == frame_len(m)) begin
        pos[m] = 0;
      end else begin
        pos[m] = pos[m] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_parity", o1, model_out(pos[1], fdat[1], 1'b1));
      check("model_noparity", o0, model_out(pos[0], fdat[0], 1'b0));
    end
  end

  typedef struct {
    logic         st;
    logic [W-1:0] d;
    logic [3:0]   e1;
    logic [3:0]   e0;
  } vec_t;

  vec_t vecs [$];

  task automatic row(input logic st, input logic [W-1:0] d, input logic [3:0] e1, input logic [3:0] e0);
    vec_t v;
    v.st = st;
    v.d  = d;
    v.e1 = e1;
    v.e0 = e0;
    vecs.push_back(v);
  endtask

  initial begin
    // Frame A5 with payload changed after acceptance and a start re-pulse in cycle 4.
    row(1, 8'hA5, B1, B1); row(0, 8'h00, B0, B0); row(0, 8'h00, B1, B1); row(0, 8'h00, B0, B0);
    row(1, 8'hFF, B0, B0); row(0, 8'h00, B1, B1); row(0, 8'h00, B0, B0); row(0, 8'h00, B1, B1);
    row(0, 8'h00, B0, DN); row(0, 8'h00, DN, ID); row(0, 8'h00, ID, ID); row(0, 8'h00, ID, ID);
    // Frame 01: parity bit is 1.
    row(1, 8'h01, B0, B0); row(0, 8'hFF, B0, B0); row(0, 8'hFF, B0, B0); row(0, 8'hFF, B0, B0);
    row(0, 8'hFF, B0, B0); row(0, 8'hFF, B0, B0); row(0, 8'hFF, B0, B0); row(0, 8'hFF, B1, B1);
    row(0, 8'hFF, B1, DN); row(0, 8'hFF, DN, ID); row(0, 8'hFF, ID, ID);
    // Frame C3.
    row(1, 8'hC3, B1, B1); row(0, 8'h3C, B1, B1); row(0, 8'h3C, B0, B0); row(0, 8'h3C, B0, B0);
    row(0, 8'h3C, B0, B0); row(0, 8'h3C, B0, B0); row(0, 8'h3C, B1, B1); row(0, 8'h3C, B1, B1);
    row(0, 8'h3C, B0, DN); row(0, 8'h3C, DN, ID); row(0, 8'h3C, ID, ID);
    // Start held high with 5A: back-to-back frames separated by one idle cycle.
    row(1, 8'h5A, B0, B0); row(1, 8'h5A, B1, B1); row(1, 8'h5A, B0, B0); row(1, 8'h5A, B1, B1);
    row(1, 8'h5A, B1, B1); row(1, 8'h5A, B0, B0); row(1, 8'h5A, B1, B1); row(1, 8'h5A, B0, B0);
    row(1, 8'h5A, B0, DN); row(1, 8'h5A, DN, ID); row(1, 8'h5A, ID, B0); row(1, 8'h5A, B0, B1);
    row(0, 8'h5A, B1, B0); row(0, 8'h5A, B0, B1); row(0, 8'h5A, B1, B1); row(0, 8'h5A, B1, B0);
    row(0, 8'h5A, B0, B1); row(0, 8'h5A, B1, B0); row(0, 8'h5A, B0, DN); row(0, 8'h5A, B0, ID);
    row(0, 8'h5A, DN, ID); row(0, 8'h5A, ID, ID); row(0, 8'h5A, ID, ID);

    reset = 1'b0;
    start = 1'b0;
    data  = '0;
    repeat (3) @(negedge clk);
    check("reset_state_p1", o1, ID);
    check("reset_state_p0", o0, ID);
    #2;
    reset    = 1'b1;
    model_on = 1'b1;

    // Table phase: each row drives one cycle and checks the following cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st;
      data  = vecs[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_p1", i), o1, vecs[i].e1);
      check($sformatf("vec%0d_p0", i), o0, vecs[i].e0);
      #2;
    end

    // Reset asserted in cycle 5 of a frame aborts it at once, then stays idle without start.
    start = 1'b1;
    data  = 8'hA5;
    @(negedge clk); #2;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_cycle5_p1", o1, B0);
    #2;
    reset = 1'b0;
    #1;
    check("reset_async_p1", o1, ID);
    check("reset_async_p0", o0, ID);
    @(negedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_reset_idle_p1", o1, ID);
      check("post_reset_idle_p0", o0, ID);
    end
    #2;

    // Start on an edge while reset is low must not be accepted.
    reset = 1'b0;
    start = 1'b1;
    data  = 8'hFF;
    @(negedge clk); #2;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("no_start_in_reset_p1", o1, ID);
    check("no_start_in_reset_p0", o0, ID);
    #2;

    // Randomized phase, checked every cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      data  = W'($urandom);
      reset = ($urandom_range(0, 149) != 0);
      @(negedge clk); #2;
    end
    reset = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
